// File: rtl/aes_decrypt_ctrl.sv
// aes_decrypt_ctrl: iterative AES inverse-cipher sequencer; optional abort input enabled by AES_DEC_ABORT_EN
module aes_decrypt_ctrl (
  input  logic         clk,
  input  logic         rst,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [1:0]   switch,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_in,
  output logic [127:0] rnd_state,
  output logic         rnd_last,
  input  logic [127:0] rnd_result,
  output logic         busy
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;
  state_t       r_state, w_next;
  logic [127:0] r_data;
  logic [3:0]   r_rcnt;
  logic [3:0]   w_nr;
  logic         w_kill;
  assign w_nr      = (switch == 2'b00) ? 4'd10 : (switch == 2'b01) ? 4'd12 : 4'd14;
  assign out_data  = r_data;
  assign rnd_state = r_data;
`ifdef AES_DEC_ABORT_EN
  assign w_kill = abort && (r_state != S_IDLE);
`else
  assign w_kill = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  // next state and handshake / round-datapath controls
  always_comb begin
    in_ready  = r_state == S_IDLE;
    out_valid = r_state == S_DONE;
    busy      = r_state == S_ROUND;
    rnd_last  = (r_state == S_ROUND) && (r_rcnt == 4'd0);
    key_idx   = (r_state == S_IDLE) ? w_nr : r_rcnt;
    w_next    = w_kill                                      ? S_IDLE  :
                (r_state == S_IDLE  && in_valid)            ? S_ROUND :
                (r_state == S_ROUND && r_rcnt == 4'd0)      ? S_DONE  :
                (r_state == S_DONE  && out_ready)           ? S_IDLE  : r_state;
  end
  // cipher state and round counter; the counter holds at 0 on the final round
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_data <= '0;
      r_rcnt <= '0;
    end else if (w_kill) begin
      r_data <= '0;
      r_rcnt <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_data <= in_data ^ key_in;
      r_rcnt <= w_nr - 4'd1;
    end else if (r_state == S_ROUND) begin
      r_data <= rnd_result;
      if (r_rcnt != 4'd0) r_rcnt <= r_rcnt - 4'd1;
    end
endmodule
